// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared state, status codes and profile record for the gate sequencer.
package gate_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_ABORT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CFG = 2'd3;
  localparam int PROF_REP_W = 8;
  typedef struct packed {
    logic [7:0] tsync;
    logic [7:0] tgdel;
    logic [15:0] tgate;
    logic [15:0] tlen;
    logic [PROF_REP_W-1:0] rep;
  } prof_t;
  function automatic logic cfg_bad(prof_t p);
    return p.tgate == '0 || p.tlen == '0;
  endfunction
endpackage

// File: rtl/gate_seq_ctrl_if.sv
// gate_seq_ctrl_if: requester request bundle and tagged completion channel.
interface gate_seq_ctrl_if #(parameter int NREQ = 2, parameter int REP_W = 4, parameter int CNT_W = 24);
  localparam int ID_W = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0][7:0] req_tsync;
  logic [NREQ-1:0][7:0] req_tgdel;
  logic [NREQ-1:0][15:0] req_tgate;
  logic [NREQ-1:0][15:0] req_tlen;
  logic [NREQ-1:0][REP_W-1:0] req_rep;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [1:0] rsp_err;
  logic [CNT_W-1:0] rsp_gates;
  modport master (output req_valid, req_tsync, req_tgdel, req_tgate, req_tlen, req_rep, rsp_ready,
                  input req_ready, rsp_valid, rsp_id, rsp_err, rsp_gates);
  modport slave (input req_valid, req_tsync, req_tgdel, req_tgate, req_tlen, req_rep, rsp_ready,
                 output req_ready, rsp_valid, rsp_id, rsp_err, rsp_gates);
endinterface

// File: rtl/gate_seq_rr_arb.sv
// gate_seq_rr_arb: round-robin arbiter, combinational grant, pointer moves only on accept.
module gate_seq_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);
  logic [ID_W-1:0] last;
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    // scan farthest-first so the nearest valid index after last wins
    for (int i = NREQ; i >= 1; i--)
      if (req[(int'(last) + i) % NREQ]) begin
        grant_idx = ID_W'((int'(last) + i) % NREQ);
        any = 1'b1;
      end
    grant = any ? NREQ'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= ID_W'(NREQ - 1);
    else if (accept) last <= grant_idx;
endmodule

// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: arbitrates requesters, sequences the sync/gate generator, returns tagged gate counts.
// Define GATE_SEQ_TIMEOUT_EN to add a RUN watchdog that ends the job with a timeout status.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CNT_W = 24,
  parameter int REP_W = 4,
  parameter int TO_LIMIT = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_seq_ctrl_if.slave       bus,
  input  logic                 abort,
  output logic                 gen_ena,
  output logic [7:0]           gen_tsync,
  output logic [7:0]           gen_tgdel,
  output logic [15:0]          gen_tgate,
  output logic [15:0]          gen_tlen,
  input  logic                 gen_sync,
  input  logic                 gen_gate,
  input  logic                 gen_done
);
  localparam int ID_W = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state;
  prof_t prof, nprof;
  logic [CNT_W-1:0] gates;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] gidx;
  logic any, to_hit, stop;
  logic [1:0] stop_err;
  logic unused_ok;
  assign unused_ok = gen_sync;
`ifdef GATE_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_LIMIT + 1);
  logic [TO_W-1:0] to_cnt;
  assign to_hit = to_cnt == TO_W'(TO_LIMIT - 1);
`else
  localparam int unused_to = TO_LIMIT;
  assign to_hit = 1'b0;
`endif
  gate_seq_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(bus.req_valid), .accept(state == IDLE && any),
    .grant(grant), .grant_idx(gidx), .any(any)
  );
  assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign nprof = '{tsync: bus.req_tsync[gidx], tgdel: bus.req_tgdel[gidx], tgate: bus.req_tgate[gidx],
                   tlen: bus.req_tlen[gidx], rep: PROF_REP_W'(bus.req_rep[gidx][REP_W-1:0])};
  assign {gen_tsync, gen_tgdel, gen_tgate, gen_tlen} = {prof.tsync, prof.tgdel, prof.tgate, prof.tlen};
  assign bus.rsp_gates = gates;
  // abort outranks done, and a done in the same cycle as the watchdog still completes normally
  assign stop = abort || (gen_done && prof.rep == '0) || (to_hit && !gen_done);
  assign stop_err = abort ? ERR_ABORT : gen_done ? ERR_OK : ERR_TIMEOUT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      prof <= '0;
      gates <= '0;
      gen_ena <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= ERR_OK;
      bus.rsp_id <= '0;
`ifdef GATE_SEQ_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else case (state)
      IDLE: if (any) begin
        prof <= nprof;
        bus.rsp_id <= gidx;
        gates <= '0;
        if (cfg_bad(nprof)) begin
          bus.rsp_err <= ERR_CFG;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end else state <= LOAD;
      end
      LOAD: begin
`ifdef GATE_SEQ_TIMEOUT_EN
        to_cnt <= '0;
`endif
        if (abort) begin
          bus.rsp_err <= ERR_ABORT;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          gen_ena <= 1'b1;
          state <= RUN;
        end
      end
      RUN: begin
`ifdef GATE_SEQ_TIMEOUT_EN
        to_cnt <= to_cnt + 1'b1;
`endif
        if (gen_gate && !(&gates)) gates <= gates + 1'b1;
        if (stop) begin
          gen_ena <= 1'b0;
          bus.rsp_err <= stop_err;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end else if (gen_done) begin
          prof.rep <= prof.rep - 1'b1;
          gen_ena <= 1'b0;
          state <= LOAD;
        end
      end
      RESP: if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb_gate_seq_ctrl: directed vector table plus hand sequences for gate_seq_ctrl with a simple generator model.
module tb_gate_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
  logic gen_ena, gen_sync, gen_gate, gen_done;
  logic [7:0] gen_tsync, gen_tgdel;
  logic [15:0] gen_tgate, gen_tlen;
  int n_cmp = 0, n_bad = 0, gcnt = 0;
  bit done_en = 1'b1;
  gate_seq_ctrl_if #(.NREQ(2), .REP_W(4), .CNT_W(24)) bus ();
  gate_seq_ctrl #(.NREQ(2), .CNT_W(24), .REP_W(4), .TO_LIMIT(50)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .abort(abort), .gen_ena(gen_ena),
    .gen_tsync(gen_tsync), .gen_tgdel(gen_tgdel), .gen_tgate(gen_tgate), .gen_tlen(gen_tlen),
    .gen_sync(gen_sync), .gen_gate(gen_gate), .gen_done(gen_done)
  );
  always #5 clk = ~clk;
  // generator model: gate high for tgate enabled cycles, done on the last of them
  initial begin
    gen_sync = 1'b0; gen_gate = 1'b0; gen_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      gcnt = gen_ena ? gcnt + 1 : 0;
      gen_sync = gen_ena && gcnt == 1;
      gen_gate = gen_ena && gcnt <= int'(gen_tgate);
      gen_done = done_en && gen_ena && gcnt == int'(gen_tgate);
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
  typedef struct {
    int idx;
    logic [7:0] tsync, tgdel;
    logic [15:0] tgate, tlen;
    logic [3:0] rep;
    logic [1:0] err;
    int gates, wins, hold;
  } vec_t;
  vec_t tab[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals();
    chk("rst_ena", gen_ena, 0);
    chk("rst_prof", {gen_tsync, gen_tgdel, gen_tgate, gen_tlen}, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_gates}, 0);
  endtask
  task automatic wait_ready();
    int k = 0;
    #1;
    while (bus.req_ready == 0 && k < 20) begin @(negedge clk); #1; k++; end
    chk("ready_wait", k < 20, 1);
  endtask
  task automatic set_prof(input vec_t v);
    bus.req_tsync[v.idx] = v.tsync; bus.req_tgdel[v.idx] = v.tgdel;
    bus.req_tgate[v.idx] = v.tgate; bus.req_tlen[v.idx] = v.tlen; bus.req_rep[v.idx] = v.rep;
  endtask
  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_clear", bus.rsp_valid, 0);
  endtask
  task automatic run_job(input vec_t v);
    int k = 0, wins = 0, gap = 0;
    logic prev = 1'b0;
    @(negedge clk);
    set_prof(v);
    bus.req_valid = 2'(1 << v.idx);
    wait_ready();
    chk("req_ready", bus.req_ready, 1 << v.idx);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk("ena_load", gen_ena, 0);
    while (!bus.rsp_valid && k < 1000) begin
      if (gen_ena && !prev) begin
        wins++;
        if (wins == 1) chk("ena_latency", k, 1);
        else chk("rearm_gap", gap, 1);
        chk("gen_prof", {gen_tsync, gen_tgdel, gen_tgate, gen_tlen}, {v.tsync, v.tgdel, v.tgate, v.tlen});
        gap = 0;
      end else if (!gen_ena && wins > 0) gap++;
      prev = gen_ena;
      @(negedge clk);
      k++;
    end
    chk("rsp_wait", k < 1000, 1);
    chk("ena_off", gen_ena, 0);
    chk("windows", wins, v.wins);
    chk("rsp_fields", {bus.rsp_err, bus.rsp_id, bus.rsp_gates}, {v.err, 1'(v.idx), 24'(v.gates)});
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_gates}, {1'b1, v.err, 24'(v.gates)});
    end
    ack();
  endtask
  initial begin
    int k, nd, hi;
    logic seen;
    vec_t a;
    tab[0] = '{0, 8'd2, 8'd1, 16'd5, 16'd20, 4'd0, 2'd0, 5, 1, 0};
    tab[1] = '{1, 8'd1, 8'd1, 16'd4, 16'd10, 4'd2, 2'd0, 12, 3, 1};
    tab[2] = '{1, 8'd1, 8'd1, 16'd3, 16'd0, 4'd0, 2'd3, 0, 0, 0};
    tab[3] = '{0, 8'd0, 8'd0, 16'd0, 16'd5, 4'd1, 2'd3, 0, 0, 2};
    tab[4] = '{0, 8'd3, 8'd2, 16'd7, 16'd30, 4'd1, 2'd0, 14, 2, 3};
    bus.req_valid = '0; bus.rsp_ready = 1'b0;
    bus.req_tsync = '0; bus.req_tgdel = '0; bus.req_tgate = '0; bus.req_tlen = '0; bus.req_rep = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    // both requesters held valid: grants must alternate starting with requester 0
    a = '{0, 8'd1, 8'd1, 16'd2, 16'd3, 4'd0, 2'd0, 2, 1, 0};
    set_prof(a);
    a.idx = 1;
    set_prof(a);
    @(negedge clk);
    bus.req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_ready();
      chk("alt_grant", bus.req_ready, (j % 2) ? 2'b10 : 2'b01);
      chk("alt_onehot", $countones(bus.req_ready), 1);
      k = 0;
      @(negedge clk);
      while (!bus.rsp_valid && k < 100) begin @(negedge clk); k++; end
      chk("alt_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_gates}, {1'(j % 2), 2'd0, 24'd2});
      if (j == 3) bus.req_valid = '0;
      ack();
    end
    foreach (tab[i]) run_job(tab[i]);
    // abort while idle is ignored
    @(negedge clk); abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", {bus.rsp_valid, gen_ena}, 0);
    // abort coinciding with the final gen_done
    a = '{0, 8'd0, 8'd0, 16'd3, 16'd5, 4'd1, 2'd1, 6, 2, 3};
    set_prof(a);
    bus.req_valid = 2'b01;
    wait_ready();
    @(posedge clk); #1 bus.req_valid = '0;
    nd = 0; k = 0;
    while (nd < 2 && k < 100) begin @(negedge clk); if (gen_done) nd++; k++; end
    chk("done_wait", nd, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ena", gen_ena, 0);
    chk("abort_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_gates}, {1'b1, 2'd1, 24'd6});
    for (int h = 0; h < 3; h++) begin
      abort = (h == 1);
      @(negedge clk);
      chk("abort_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_gates}, {1'b1, 2'd1, 24'd6});
    end
    abort = 1'b0;
    ack();
    // reset in the middle of RUN drops the job
    a = '{0, 8'd4, 8'd4, 16'd200, 16'd300, 4'd0, 2'd0, 0, 0, 0};
    set_prof(a);
    bus.req_valid = 2'b01;
    wait_ready();
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (6) @(negedge clk);
    chk("mid_ena", gen_ena, 1);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= bus.rsp_valid | gen_ena; end
    chk("no_rsp_after_rst", seen, 0);
`ifdef GATE_SEQ_TIMEOUT_EN
    done_en = 1'b0;
    a = '{0, 8'd0, 8'd0, 16'd100, 16'd200, 4'd0, 2'd2, 50, 1, 0};
    set_prof(a);
    bus.req_valid = 2'b01;
    wait_ready();
    @(posedge clk); #1 bus.req_valid = '0;
    hi = 0; k = 0;
    while (!bus.rsp_valid && k < 300) begin @(negedge clk); if (gen_ena) hi++; k++; end
    chk("to_ena_cycles", hi, 50);
    chk("to_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_gates}, {1'b1, 2'd2, 24'd50});
    done_en = 1'b1;
    ack();
`else
    hi = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
